// File: rtl/biu_constants_pkg.sv
// BIU transfer encodings: access size and burst type, plus a helper that
// maps a beat count onto the matching burst type.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } biu_type_t;

    // Fixed-length burst matching one cache line; unsupported lengths fall back to INCR
    function automatic biu_type_t biu_burst_type(input int unsigned beats, input logic wrap);
        case (beats)
            4:       return wrap ? WRAP4  : INCR4;
            8:       return wrap ? WRAP8  : INCR8;
            16:      return wrap ? WRAP16 : INCR16;
            default: return INCR;
        endcase
    endfunction

endpackage

// File: rtl/riscv_cache_pkg.sv
// Cache-to-BIU command encoding and the line-transfer engine state enum.
package riscv_cache_pkg;

    typedef enum logic [1:0] {
        BIUCMD_NOP      = 2'b00,
        BIUCMD_READWAY  = 2'b01,
        BIUCMD_WRITEWAY = 2'b10
    } biucmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_BURST = 2'b10,
        ST_DONE  = 2'b11
    } xfer_state_t;

endpackage

// File: rtl/riscv_cache_biu_xfer.sv
// Line-transfer engine: one BIU burst per cache fill/evict command.
// Define RV_CACHE_CRITICAL_WORD_FIRST_EN for wrapping, critical-word-first fills.
module riscv_cache_biu_xfer
    import riscv_cache_pkg::*;
    import biu_constants_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PLEN       = XLEN,
    parameter int unsigned BLOCK_SIZE = XLEN
) (
    input  logic                      rst_ni,
    input  logic                      clk_i,

    input  biucmd_t                   biucmd_i,
    input  logic [PLEN-1:0]           biucmd_adr_i,
    input  logic                      biucmd_dirty_i,
    input  logic [BLOCK_SIZE*8-1:0]   evict_line_i,
    output logic                      biucmd_busy_o,
    output logic                      biucmd_ack_o,
    output logic                      biucmd_err_o,
    output logic [BLOCK_SIZE*8-1:0]   biu_line_o,
    output logic                      biu_line_dirty_o,

    output logic                      biu_stb_o,
    input  logic                      biu_stb_ack_i,
    input  logic                      biu_d_ack_i,
    input  logic                      biu_err_i,
    output logic [PLEN-1:0]           biu_adri_o,
    output logic                      biu_we_o,
    output biu_size_t                 biu_size_o,
    output biu_type_t                 biu_type_o,
    output logic [XLEN-1:0]           biu_d_o,
    input  logic [XLEN-1:0]           biu_q_i
);

    localparam int unsigned BLK_BITS = BLOCK_SIZE * 8;
    localparam int unsigned BEATS    = BLK_BITS / XLEN;
    localparam int unsigned CNT_W    = $clog2(BEATS);
    localparam int unsigned WORD_OFF = $clog2(XLEN / 8);

`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
    localparam logic CWF = 1'b1;
`else
    localparam logic CWF = 1'b0;
`endif

    localparam biu_type_t BURST_TYPE = biu_burst_type(BEATS, CWF);

    xfer_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    ptr_q, ptr_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                stb_q, stb_d;
    logic                dirty_q, dirty_d;
    logic [BLK_BITS-1:0] line_q, line_d;
    logic [BLK_BITS-1:0] evict_q, evict_d;
    logic [XLEN-1:0]     d_q, d_d;
    logic [PLEN-1:0]     adri_q, adri_d;
    biu_type_t           type_q, type_d;
    logic                rd_c;
    logic                beat_c;

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        stb_d   = stb_q;
        dirty_d = dirty_q;
        line_d  = line_q;
        evict_d = evict_q;
        d_d     = d_q;
        adri_d  = adri_q;
        type_d  = type_q;
        rd_c    = (biucmd_i == BIUCMD_READWAY);
        beat_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (biucmd_i != BIUCMD_NOP) begin
                    state_d = ST_REQ;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    we_d    = ~rd_c;
                    dirty_d = biucmd_dirty_i;
                    evict_d = evict_line_i;
                    cnt_d   = '0;
                    type_d  = BURST_TYPE;
                    // Only wrapping fills start mid-line; evicts always start at word 0
                    if (CWF && rd_c) begin
                        ptr_d  = biucmd_adr_i[WORD_OFF +: CNT_W];
                        adri_d = biucmd_adr_i & ~PLEN'(XLEN / 8 - 1);
                    end else begin
                        ptr_d  = '0;
                        adri_d = biucmd_adr_i & ~PLEN'(BLOCK_SIZE - 1);
                    end
                    if (!rd_c) d_d = evict_line_i[XLEN-1:0];
                end
            end
            ST_REQ: begin
                if (biu_err_i) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (biu_stb_ack_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_BURST;
                    beat_c  = biu_d_ack_i;
                end
            end
            ST_BURST: begin
                if (biu_err_i) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (biu_d_ack_i) begin
                    beat_c = 1'b1;
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // One data beat: store fill word or advance write data
        if (beat_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            ptr_d = ptr_q + CNT_W'(1);
            if (!we_q) line_d[ptr_q*XLEN +: XLEN] = biu_q_i;
            else       d_d = evict_q[ptr_d*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            dirty_q <= 1'b0;
            line_q  <= '0;
            evict_q <= '0;
            d_q     <= '0;
            adri_q  <= '0;
            type_q  <= SINGLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            dirty_q <= dirty_d;
            line_q  <= line_d;
            evict_q <= evict_d;
            d_q     <= d_d;
            adri_q  <= adri_d;
            type_q  <= type_d;
        end
    end

    assign biucmd_busy_o    = busy_q;
    assign biucmd_ack_o     = ack_q;
    assign biucmd_err_o     = err_q;
    assign biu_line_o       = line_q;
    assign biu_line_dirty_o = dirty_q;
    assign biu_stb_o        = stb_q;
    assign biu_adri_o       = adri_q;
    assign biu_we_o         = we_q;
    assign biu_size_o       = WORD;
    assign biu_type_o       = type_q;
    assign biu_d_o          = d_q;

endmodule

// File: tb/tb_riscv_cache_biu_xfer.sv
// Self-checking bench for riscv_cache_biu_xfer (XLEN=32, 16-byte lines, 4 beats).
module tb_riscv_cache_biu_xfer;
    import riscv_cache_pkg::*;
    import biu_constants_pkg::*;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned PLEN       = 32;
    localparam int unsigned BLOCK_SIZE = 16;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned BLK        = 128;

`ifdef RV_CACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic            rst_ni, clk_i;
    biucmd_t         biucmd_i;
    logic [PLEN-1:0] biucmd_adr_i;
    logic            biucmd_dirty_i;
    logic [BLK-1:0]  evict_line_i;
    logic            biucmd_busy_o, biucmd_ack_o, biucmd_err_o;
    logic [BLK-1:0]  biu_line_o;
    logic            biu_line_dirty_o;
    logic            biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_err_i;
    logic [PLEN-1:0] biu_adri_o;
    logic            biu_we_o;
    biu_size_t       biu_size_o;
    biu_type_t       biu_type_o;
    logic [XLEN-1:0] biu_d_o, biu_q_i;

    int total = 0;
    int bad   = 0;

    riscv_cache_biu_xfer #(.XLEN(XLEN), .PLEN(PLEN), .BLOCK_SIZE(BLOCK_SIZE)) dut (
        .rst_ni(rst_ni), .clk_i(clk_i),
        .biucmd_i(biucmd_i), .biucmd_adr_i(biucmd_adr_i), .biucmd_dirty_i(biucmd_dirty_i),
        .evict_line_i(evict_line_i), .biucmd_busy_o(biucmd_busy_o), .biucmd_ack_o(biucmd_ack_o),
        .biucmd_err_o(biucmd_err_o), .biu_line_o(biu_line_o), .biu_line_dirty_o(biu_line_dirty_o),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
        .biu_err_i(biu_err_i), .biu_adri_o(biu_adri_o), .biu_we_o(biu_we_o),
        .biu_size_o(biu_size_o), .biu_type_o(biu_type_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs set and outputs sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  biucmd_busy_o, 0);
        check({tag, "_ack"},   biucmd_ack_o, 0);
        check({tag, "_err"},   biucmd_err_o, 0);
        check({tag, "_stb"},   biu_stb_o, 0);
        check({tag, "_we"},    biu_we_o, 0);
        check({tag, "_dirty"}, biu_line_dirty_o, 0);
        check({tag, "_line"},  biu_line_o, 0);
        check({tag, "_d"},     biu_d_o, 0);
        check({tag, "_adri"},  biu_adri_o, 0);
        check({tag, "_type"},  biu_type_o, SINGLE);
        check({tag, "_size"},  biu_size_o, WORD);
    endtask

    // One complete command; qline holds read data by beat order (beat k = word k)
    task automatic run_xfer(input biucmd_t cmd, input logic [31:0] adr, input logic dirty,
                            input logic [BLK-1:0] evict, input logic [BLK-1:0] qline,
                            input int stb_delay, input bit same, input int err_beat,
                            input bit hold, input bit gaps);
        logic [BLK-1:0] exp_line;
        logic [31:0]    exp_adri;
        biu_type_t      exp_type;
        bit             rd;
        int             start;
        int             k;
        rd       = (cmd == BIUCMD_READWAY);
        start    = (CWF && rd) ? int'((adr / 4) % BEATS) : 0;
        exp_adri = (CWF && rd) ? (adr & ~32'h3) : (adr & ~32'hF);
        exp_type = CWF ? WRAP4 : INCR4;
        exp_line = '0;

        biucmd_i = cmd; biucmd_adr_i = adr; biucmd_dirty_i = dirty; evict_line_i = evict;
        step();
        biucmd_i     = hold ? (rd ? BIUCMD_WRITEWAY : BIUCMD_READWAY) : BIUCMD_NOP;
        biucmd_adr_i = $urandom;
        biucmd_dirty_i = ~dirty;
        evict_line_i = {$urandom, $urandom, $urandom, $urandom};
        check("busy_rise", biucmd_busy_o, 1);
        check("stb_rise", biu_stb_o, 1);
        check("we", biu_we_o, !rd);
        check("dirty", biu_line_dirty_o, dirty);
        check("adri", biu_adri_o, exp_adri);
        check("type", biu_type_o, exp_type);

        for (int i = 0; i < stb_delay; i++) begin
            step();
            check("stb_held", biu_stb_o, 1);
        end
        if (!same) begin
            biu_stb_ack_i = 1'b1;
            step();
            biu_stb_ack_i = 1'b0;
            check("stb_drop", biu_stb_o, 0);
        end else begin
            biu_stb_ack_i = 1'b1;
        end

        k = 0;
        while (k < BEATS) begin
            if (gaps && !(k == 0 && same) && $urandom_range(0, 2) == 0) begin
                biu_q_i = $urandom;
                step();
                check("gap_ack", biucmd_ack_o, 0);
                if (!rd) check("gap_d", biu_d_o, evict[k*32 +: 32]);
            end
            if (k == err_beat) begin
                biu_err_i = 1'b1;
                step();
                biu_err_i = 1'b0;
                biucmd_i  = BIUCMD_NOP;
                check("err_pulse", biucmd_err_o, 1);
                check("err_noack", biucmd_ack_o, 0);
                step();
                check("err_busy", biucmd_busy_o, 0);
                check("err_once", biucmd_err_o, 0);
                check("err_noack2", biucmd_ack_o, 0);
                return;
            end
            biu_d_ack_i = 1'b1;
            biu_q_i     = rd ? qline[k*32 +: 32] : $urandom;
            if (!rd) check("d_beat", biu_d_o, evict[k*32 +: 32]);
            check("no_early_ack", biucmd_ack_o, 0);
            step();
            biu_d_ack_i   = 1'b0;
            biu_stb_ack_i = 1'b0;
            biu_q_i       = $urandom;
            if (k == 0 && same) check("stb_drop_same", biu_stb_o, 0);
            if (rd) exp_line[((start + k) % BEATS)*32 +: 32] = qline[k*32 +: 32];
            k++;
        end

        biucmd_i = BIUCMD_NOP;
        check("ack", biucmd_ack_o, 1);
        check("busy_done", biucmd_busy_o, 1);
        check("no_err", biucmd_err_o, 0);
        if (rd) check("line", biu_line_o, exp_line);
        step();
        check("ack_once", biucmd_ack_o, 0);
        check("busy_fall", biucmd_busy_o, 0);
        if (rd) check("line_stable", biu_line_o, exp_line);
    endtask

    initial begin
        rst_ni = 1'b0;
        biucmd_i = BIUCMD_NOP; biucmd_adr_i = '0; biucmd_dirty_i = 1'b0; evict_line_i = '0;
        biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_err_i = 1'b0; biu_q_i = '0;
        step();
        step();
        rst_ni = 1'b1;
        check_reset_vals("rst");
        step();
        check("idle_nop", biucmd_busy_o, 0);

        // Plain fill, then eviction back-to-back
        run_xfer(BIUCMD_READWAY, 32'h1000, 1'b1, '0,
                 {32'hD, 32'hC, 32'hB, 32'hA}, 0, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(BIUCMD_WRITEWAY, 32'h2000, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1},
                 '0, 0, 1'b0, -1, 1'b0, 1'b0);
        // Mid-line miss address (critical word first when enabled)
        run_xfer(BIUCMD_READWAY, 32'h1008, 1'b0, '0,
                 {32'hB, 32'hA, 32'hD, 32'hC}, 0, 1'b0, -1, 1'b0, 1'b0);
        // Bus error on beat 2
        run_xfer(BIUCMD_READWAY, 32'h3000, 1'b0, '0,
                 {32'h4, 32'h3, 32'h2, 32'h1}, 0, 1'b0, 2, 1'b0, 1'b0);
        // Slow stb_ack with data in the same cycle, while a new command is held
        run_xfer(BIUCMD_READWAY, 32'h4004, 1'b1, '0,
                 {32'h44, 32'h33, 32'h22, 32'h11}, 5, 1'b1, -1, 1'b1, 1'b0);
        run_xfer(BIUCMD_WRITEWAY, 32'h5000, 1'b0, {32'h8, 32'h7, 32'h6, 32'h5},
                 '0, 3, 1'b1, -1, 1'b1, 1'b0);

        // Reset asserted during beat 1
        biucmd_i = BIUCMD_READWAY; biucmd_adr_i = 32'h6000;
        step();
        biucmd_i = BIUCMD_NOP;
        biu_stb_ack_i = 1'b1; biu_d_ack_i = 1'b1; biu_q_i = 32'h1111_1111;
        step();
        biu_stb_ack_i = 1'b0; biu_q_i = 32'h2222_2222;
        rst_ni = 1'b0;
        #1;
        check_reset_vals("midrst");
        biu_d_ack_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_idle", biucmd_busy_o, 0);
        run_xfer(BIUCMD_READWAY, 32'h7000, 1'b0, '0,
                 {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000}, 1, 1'b0, -1, 1'b0, 1'b0);

        // Randomised commands against the model
        for (int n = 0; n < 30; n++) begin
            run_xfer(($urandom_range(0, 1) == 0) ? BIUCMD_READWAY : BIUCMD_WRITEWAY,
                     $urandom, 1'($urandom),
                     {$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom},
                     int'($urandom_range(0, 3)), 1'($urandom),
                     ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : -1,
                     1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_cache_biu_xfer.md
# riscv_cache_biu_xfer

Bus-side line-transfer engine between the cache controller and the BIU. It answers the cache's fill/evict commands by running one burst per cache line on the BIU. Fills are assembled into `biu_line_o` and acknowledged with `biucmd_ack_o`; evicted lines are serialised one word per beat onto `biu_d_o`. It is the responder end of the cache-memory fill/evict handshake (`biu_line`, `biu_line_dirty`, `biucmd_ack`, `evict_line`, `evict_tag`).

## Interface
Parameters:
- `XLEN`, default 32: data word width.
- `PLEN`, default `XLEN`: physical address width.
- `BLOCK_SIZE`, default `XLEN`: line size in bytes.
  - `BLK_BITS = BLOCK_SIZE*8`.
  - `BEATS = BLK_BITS/XLEN`; power of 2, ≥2.

Ports:
- `rst_ni`  in  1  Reset: asynchronous, active-low.
- `clk_i`  in  1  Clock.
- `biucmd_i`  in  `biucmd_t`  NOP / READWAY (fill) / WRITEWAY (evict).
- `biucmd_adr_i`  in  `PLEN`  Miss address (fill) or evict address (`{evict_tag,idx,0}`).
- `biucmd_dirty_i`  in  1  Dirty flag to return with the fill.
- `evict_line_i`  in  `BLK_BITS`  Line to write back; sampled at command accept.
- `biucmd_busy_o`  out  1  Engine not IDLE.
- `biucmd_ack_o`  out  1  One-cycle pulse: transfer complete.
- `biucmd_err_o`  out  1  One-cycle pulse: transfer aborted by `biu_err_i`.
- `biu_line_o`  out  `BLK_BITS`  Assembled fill line.
- `biu_line_dirty_o`  out  1  Registered `biucmd_dirty_i`.
- `biu_stb_o`  out  1  Burst request.
- `biu_stb_ack_i`  in  1  Burst request accepted.
- `biu_d_ack_i`  in  1  One beat transferred.
- `biu_err_i`  in  1  Bus error.
- `biu_adri_o`  out  `PLEN`  Burst start address.
- `biu_we_o`  out  1  1 = write burst.
- `biu_size_o`  out  `biu_size_t`  Always WORD.
- `biu_type_o`  out  `biu_type_t`  INCR<BEATS> or WRAP<BEATS>.
- `biu_d_o`  out  `XLEN`  Write data for the current beat.
- `biu_q_i`  in  `XLEN`  Read data, valid with `biu_d_ack_i`.

## Operation
- FSM states: IDLE, REQ, BURST, DONE.
- **IDLE**
  - A non-NOP `biucmd_i` is accepted: latch address, `we`, dirty and `evict_line_i`.
  - Beat counter `cnt` is cleared; word pointer `ptr` is loaded with the start word.
  - Go to REQ.
  - NOP stays in IDLE.
- **REQ**
  - `biu_stb_o` = 1 and is held until `biu_stb_ack_i`, then go to BURST.
  - `biu_d_ack_i` in the same cycle as `biu_stb_ack_i` counts as beat 0.
- **BURST**
  - Each `biu_d_ack_i` increments `cnt`; `ptr` = (`ptr`+1) mod `BEATS`.
  - Read: `biu_q_i` is written into word `ptr` of `biu_line_o`.
  - Write: `biu_d_o` = word `ptr` of the latched evict line.
  - The ack with `cnt == BEATS-1` moves to DONE.
- **DONE**
  - `biucmd_ack_o` = 1 for exactly one cycle, then IDLE.
  - `biu_line_o` is stable from this cycle until the next READWAY beat.
- **Error:** `biu_err_i` in REQ or BURST gives an `biucmd_err_o` pulse the next cycle, return to IDLE, and no `biucmd_ack_o`. The partial `biu_line_o` must not be used.
- **Commands while busy** are ignored; the controller holds its command until it sees `biucmd_busy_o` = 0.
- **Widths:** `cnt` and `ptr` are `$clog2(BEATS)` bits and wrap naturally.
- **Address:** `biu_adri_o` is word-aligned (low `$clog2(XLEN/8)` bits zero).
- **Reset mid-burst:** FSM returns to IDLE. Terminating the bus side is the BIU's job.

## Timing
- **Reset values:**
  - `biucmd_busy_o`, `biucmd_ack_o`, `biucmd_err_o`, `biu_stb_o`, `biu_we_o`, `biu_line_dirty_o`: 0.
  - `biu_line_o`, `biu_d_o`, `biu_adri_o`: 0.
  - `biu_type_o`: SINGLE. `biu_size_o`: WORD.
- **Command to bus:** command in cycle 0 gives `biu_stb_o` and `biucmd_busy_o` high in cycle 1 (registered).
- **Completion:** last `biu_d_ack_i` in cycle N gives `biucmd_ack_o` in cycle N+1.
  - `biucmd_busy_o` stays high through N+1 and drops in cycle N+2.
- **Back-to-back:** earliest next accept is cycle N+2.
- **`biu_d_o`** changes only in the cycle after a `biu_d_ack_i`.

## Configuration
- **`RV_CACHE_CRITICAL_WORD_FIRST_EN` defined:**
  - `biu_adri_o` = miss word address; `biu_type_o` = WRAP<BEATS>.
  - `ptr` starts at the word offset of `biucmd_adr_i`, so the returned words fill the line rotated.
  - Evicts always use start offset 0.
- **Undefined:**
  - `biu_adri_o` = line-aligned address; `biu_type_o` = INCR<BEATS>; `ptr` starts at 0.

## Structure
- `riscv_cache_pkg`: `biucmd_t` and the FSM state enum.
- `biu_constants_pkg`: `biu_size_t` and `biu_type_t`.
- Single module; no sub-module.

## Test plan
Setup: `XLEN=32`, `BLOCK_SIZE=16` (`BEATS=4`).
- READWAY, adr `0x1000`, `biu_q_i` = 0xA,0xB,0xC,0xD → `biu_line_o = 0x0000000D_0000000C_0000000B_0000000A`, `biucmd_ack_o` one cycle after the 4th ack.
- WRITEWAY, evict line `{4,3,2,1}` → `biu_we_o` = 1 and `biu_d_o` = 1,2,3,4 on successive acks, then one `biucmd_ack_o`.
- Macro on, READWAY adr `0x1008` → `biu_adri_o` = `0x1008`, `biu_type_o` = WRAP4, data 0xC,0xD,0xA,0xB ends in words 2,3,0,1.
- `biu_err_i` at beat 2 → `biucmd_err_o` pulse, no `biucmd_ack_o`, `biucmd_busy_o` low two cycles later.
- `biu_stb_ack_i` delayed 5 cycles, with `biu_d_ack_i` in the same cycle as `stb_ack` → `biu_stb_o` held for all 5 cycles, and that ack counts as beat 0.
- `rst_ni` low at beat 1 → all outputs return to reset values; the next command completes normally.
